// File: rtl/conv_pass_sequencer.sv
// Drives a filter CPU through a requested number of back-to-back 5x5 convolution
// passes, chaining each pass's output size into the next and reporting the outcome.
module conv_pass_sequencer #(
  parameter int DIM_W   = 17,
  parameter int PASS_W  = 4,
  parameter int KSIZE   = 5,
  parameter int RST_CYC = 2,
  parameter int TMO_W   = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  img_row,
  input  logic [DIM_W-1:0]  img_column,
  input  logic [PASS_W-1:0] num_pass,
  input  logic              cpu_end,
  input  logic [DIM_W-1:0]  cpu_next_row,
  input  logic [DIM_W-1:0]  cpu_next_column,
  output logic              cpu_rst_n,
  output logic [DIM_W-1:0]  cpu_row,
  output logic [DIM_W-1:0]  cpu_column,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [PASS_W-1:0] pass_cnt,
  output logic [DIM_W-1:0]  final_row,
  output logic [DIM_W-1:0]  final_column
);

  localparam int               RC_W     = $clog2(RST_CYC + 1);
  localparam logic [DIM_W-1:0] KMIN     = DIM_W'(KSIZE);
  localparam logic [1:0]       CODE_DIM = 2'd1;
  localparam logic [1:0]       CODE_TMO = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE, S_CHK, S_RST, S_ARM, S_RUN, S_DONE, S_ERR
  } state_t;

  state_t              state, state_next;
  logic [RC_W-1:0]     rst_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [PASS_W-1:0]   pass_target;
  logic                cpu_rst_n_next;
  logic                capture, complete, err_load;
  logic [1:0]          err_val;
  logic                tmo_hit;

  assign tmo_hit = &tmo_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cpu_rst_n <= 1'b0;
    end else begin
      state     <= state_next;
      cpu_rst_n <= cpu_rst_n_next;
    end
  end

  // NOTE: every signal written here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_next     = state;
    cpu_rst_n_next = cpu_rst_n;
    capture        = 1'b0;
    complete       = 1'b0;
    err_load       = 1'b0;
    err_val        = 2'd0;
    case (state)
      S_IDLE: begin
        if (start) begin
          capture    = 1'b1;
          state_next = S_CHK;
        end
      end
      S_CHK: begin
        if (pass_cnt == pass_target) begin
          state_next = S_DONE;
        end else if (cpu_row < KMIN || cpu_column < KMIN) begin
          err_load       = 1'b1;
          err_val        = CODE_DIM;
          cpu_rst_n_next = 1'b0;
          state_next     = S_ERR;
        end else begin
          state_next = S_RST;
        end
      end
      S_RST: begin
        // Release lands on the same edge that moves to ARM.
        if (rst_cnt == RC_W'(RST_CYC)) begin
          cpu_rst_n_next = 1'b1;
          state_next     = S_ARM;
        end else begin
          cpu_rst_n_next = 1'b0;
        end
      end
      S_ARM: begin
        if (tmo_hit) begin
          err_load       = 1'b1;
          err_val        = CODE_TMO;
          cpu_rst_n_next = 1'b0;
          state_next     = S_ERR;
        end else if (!cpu_end) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (tmo_hit) begin
          err_load       = 1'b1;
          err_val        = CODE_TMO;
          cpu_rst_n_next = 1'b0;
          state_next     = S_ERR;
        end else if (cpu_end) begin
          complete   = 1'b1;
          state_next = S_CHK;
        end
      end
      S_DONE:  state_next = S_IDLE;
      S_ERR:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rst_cnt      <= '0;
      tmo_cnt      <= '0;
      pass_target  <= '0;
      pass_cnt     <= '0;
      cpu_row      <= '0;
      cpu_column   <= '0;
      final_row    <= '0;
      final_column <= '0;
      err_code     <= 2'd0;
    end else begin
      rst_cnt <= (state == S_RST) ? rst_cnt + 1'b1 : '0;
      tmo_cnt <= (state == S_ARM || state == S_RUN) ? tmo_cnt + 1'b1 : '0;
      if (capture) begin
        pass_target  <= num_pass;
        pass_cnt     <= '0;
        cpu_row      <= img_row;
        cpu_column   <= img_column;
        final_row    <= img_row;
        final_column <= img_column;
        err_code     <= 2'd0;
      end
      if (complete) begin
        pass_cnt     <= pass_cnt + 1'b1;
        cpu_row      <= cpu_next_row;
        cpu_column   <= cpu_next_column;
        final_row    <= cpu_next_row;
        final_column <= cpu_next_column;
      end
      if (err_load) begin
        err_code <= err_val;
      end
    end
  end

  assign busy = state inside {S_CHK, S_RST, S_ARM, S_RUN};
  assign done = (state == S_DONE);
  assign err  = (state == S_ERR);

endmodule

// File: tb/tb_conv_pass_sequencer.sv
// Scoreboard bench for conv_pass_sequencer: a behavioural filter-CPU model drives
// completions, a pass-level reference predicts outcomes, a monitor compares them.
module tb_conv_pass_sequencer;

  localparam int DIM_W  = 17;
  localparam int PASS_W = 4;
  localparam int TMO_W  = 6;

  logic              clk, reset, start;
  logic [DIM_W-1:0]  img_row, img_column;
  logic [PASS_W-1:0] num_pass;
  logic              cpu_end;
  logic [DIM_W-1:0]  cpu_next_row, cpu_next_column;
  logic              cpu_rst_n;
  logic [DIM_W-1:0]  cpu_row, cpu_column;
  logic              busy, done, err;
  logic [1:0]        err_code;
  logic [PASS_W-1:0] pass_cnt;
  logic [DIM_W-1:0]  final_row, final_column;

  conv_pass_sequencer #(.DIM_W(DIM_W), .PASS_W(PASS_W), .KSIZE(5), .RST_CYC(2), .TMO_W(TMO_W)) dut (
    .clk(clk), .reset(reset), .start(start),
    .img_row(img_row), .img_column(img_column), .num_pass(num_pass),
    .cpu_end(cpu_end), .cpu_next_row(cpu_next_row), .cpu_next_column(cpu_next_column),
    .cpu_rst_n(cpu_rst_n), .cpu_row(cpu_row), .cpu_column(cpu_column),
    .busy(busy), .done(done), .err(err), .err_code(err_code), .pass_cnt(pass_cnt),
    .final_row(final_row), .final_column(final_column)
  );

  typedef struct { bit is_err; int code; int passes; int frow; int fcol; } exp_t;
  typedef struct { int r; int c; } dims_t;

  exp_t  exp_q[$];
  dims_t pass_q[$];
  int    checks = 0;
  int    errors = 0;
  bit    stuck  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Pass-level reference: each 5x5 pass shrinks both dimensions by 4.
  task automatic predict(input int r0, input int c0, input int n, input bit stk);
    exp_t e;
    int r = r0;
    int c = c0;
    e = '{is_err: 1'b0, code: 0, passes: 0, frow: r0, fcol: c0};
    for (int p = 0; p < n; p++) begin
      if (r < 5 || c < 5) begin
        e.is_err = 1'b1; e.code = 1; break;
      end
      pass_q.push_back('{r: r, c: c});
      if (stk) begin
        e.is_err = 1'b1; e.code = 2; break;
      end
      r -= 4; c -= 4;
      e.passes++; e.frow = r; e.fcol = c;
    end
    exp_q.push_back(e);
  endtask

  task automatic do_start(input int r, input int c, input int n, input bit pred);
    @(negedge clk);
    if (pred) predict(r, c, n, stuck);
    img_row    = DIM_W'(r);
    img_column = DIM_W'(c);
    num_pass   = PASS_W'(n);
    start      = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < budget);
    check("busy_timeout", int'(busy), 0);
    @(negedge clk);
  endtask

  // Filter-CPU model: on release, checks the presented size, then ends after a random latency.
  initial begin : cpu_model
    bit    was_low = 1'b1;
    bit    running = 1'b0;
    int    lat     = 0;
    dims_t d;
    cpu_end         = 1'b0;
    cpu_next_row    = '0;
    cpu_next_column = '0;
    forever begin
      @(negedge clk);
      if (!cpu_rst_n) begin
        cpu_end = stuck;
        running = 1'b0;
        was_low = 1'b1;
      end else if (was_low) begin
        was_low = 1'b0;
        cpu_end = stuck;
        running = !stuck;
        lat     = int'($urandom_range(2, 20));
        if (pass_q.size() == 0) begin
          check("unexpected_release", int'(cpu_rst_n), 0);
        end else begin
          d = pass_q.pop_front();
          check("pass_row", int'(cpu_row), d.r);
          check("pass_column", int'(cpu_column), d.c);
        end
      end else if (running) begin
        if (lat == 0) begin
          cpu_next_row    = cpu_row - DIM_W'(4);
          cpu_next_column = cpu_column - DIM_W'(4);
          cpu_end         = 1'b1;
          running         = 1'b0;
        end else begin
          lat--;
        end
      end
    end
  end

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset && (done || err)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_end", int'(done | err), 0);
        end else begin
          e = exp_q.pop_front();
          check("end_err", int'(err), int'(e.is_err));
          check("end_done", int'(done), int'(!e.is_err));
          check("err_code", int'(err_code), e.code);
          check("pass_cnt", int'(pass_cnt), e.passes);
          check("final_row", int'(final_row), e.frow);
          check("final_column", int'(final_column), e.fcol);
          check("busy_at_end", int'(busy), 0);
        end
      end
    end
  end

  initial begin : watchdog
    #900_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int k;
    reset = 1'b0; start = 1'b0;
    img_row = '0; img_column = '0; num_pass = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cpu_rst_n", int'(cpu_rst_n), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done_err", int'({done, err}), 0);
    check("rst_err_code", int'(err_code), 0);
    check("rst_pass_cnt", int'(pass_cnt), 0);
    check("rst_cpu_dims", int'(cpu_row) + int'(cpu_column), 0);
    check("rst_final_dims", int'(final_row) + int'(final_column), 0);
    @(negedge clk) reset = 1'b1;

    do_start(32, 32, 3, 1'b1);
    wait_idle(2000);

    // Release timing: start accepted at edge N -> low after N+2 and N+3, high after N+4.
    do_start(32, 32, 1, 1'b1);
    @(posedge clk) #1 check("rst_n_edge1", int'(cpu_rst_n), 1);
    @(posedge clk) #1 check("rst_n_edge2", int'(cpu_rst_n), 0);
    @(posedge clk) #1 check("rst_n_edge3", int'(cpu_rst_n), 0);
    @(posedge clk) #1 check("rst_n_edge4", int'(cpu_rst_n), 1);
    wait_idle(2000);

    do_start(12, 12, 3, 1'b1);
    wait_idle(2000);

    do_start(10, 7, 0, 1'b1);
    @(posedge clk) #1 check("n0_done_latency", int'(done), 1);
    wait_idle(20);

    // CPU completion stuck high: ARM never sees the restart, so the pass times out.
    stuck = 1'b1;
    do_start(20, 20, 2, 1'b1);
    k = 0;
    do begin @(negedge clk); k++; end while (!cpu_rst_n && k < 50);
    check("stuck_release", int'(cpu_rst_n), 1);
    k = 0;
    do begin @(negedge clk); k++; end while (!err && k < 200);
    check("tmo_window", int'(k >= 63 && k <= 65), 1);
    @(negedge clk) stuck = 1'b0;
    wait_idle(20);

    do_start(24, 24, 2, 1'b1);
    repeat (4) @(negedge clk);
    do_start(40, 40, 5, 1'b0);
    repeat (3) @(negedge clk);
    do_start(9, 33, 1, 1'b0);
    wait_idle(2000);

    // Reset in the middle of pass 2.
    do_start(30, 30, 4, 1'b1);
    k = 0;
    do begin @(negedge clk); k++; end while (!(pass_cnt == 1 && cpu_rst_n && !cpu_end) && k < 500);
    check("reach_pass2", int'(pass_cnt), 1);
    #2 reset = 1'b0;
    #1;
    check("mid_cpu_rst_n", int'(cpu_rst_n), 0);
    check("mid_busy", int'(busy), 0);
    check("mid_done_err", int'({done, err}), 0);
    check("mid_pass_cnt", int'(pass_cnt), 0);
    check("mid_cpu_dims", int'(cpu_row) + int'(cpu_column), 0);
    check("mid_final_dims", int'(final_row) + int'(final_column), 0);
    check("mid_err_code", int'(err_code), 0);
    exp_q.delete();
    pass_q.delete();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("post_rst_done_err", int'({done, err}), 0);
    do_start(15, 9, 2, 1'b1);
    wait_idle(2000);

    for (int i = 0; i < 40; i++) begin
      int r, c, n;
      r = int'($urandom_range(2, 44));
      c = int'($urandom_range(2, 44));
      n = int'($urandom_range(0, 9));
      do_start(r, c, n, 1'b1);
      wait_idle(2000);
      repeat (int'($urandom_range(0, 3))) @(negedge clk);
    end

    repeat (5) @(negedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("pass_q_drained", pass_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
